// File: rtl/cla_accum16.sv
// cla_accum16: burst accumulator built around one CLA16 adder, valid/ready in and out.
// Optional build macro CLA_ACC_SAT_EN: saturate the accumulator at 16'hFFFF on carry-out.
`timescale 1ns/1ps

module cla_accum16 #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic             out_carry,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [15:0]      r_acc;
    logic [15:0]      w_acc_nxt;
    logic             r_carry;
    logic             w_carry_nxt;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] w_rem_nxt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic [15:0]      w_cla_s;
    logic             w_cla_co;
    logic [15:0]      w_add_s;

    CLA16 u_cla (
        .A   (r_acc),
        .B   (in_data),
        .Cin (1'b0),
        .S   (w_cla_s),
        .Co  (w_cla_co)
    );

`ifdef CLA_ACC_SAT_EN
    // Any carry-out pins the total at full scale; further adds keep it there.
    assign w_add_s = w_cla_co ? 16'hFFFF : w_cla_s;
`else
    assign w_add_s = w_cla_s;
`endif

    // Next-state and datapath update for the IDLE/ACC/DONE controller.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_carry_nxt = r_carry;
        w_rem_nxt   = r_rem;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_acc_nxt   = 16'h0000;
                    w_carry_nxt = 1'b0;
                    w_rem_nxt   = len;
                    if (len != {LEN_W{1'b0}}) begin
                        w_state_nxt = ST_ACC;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    w_acc_nxt   = w_add_s;
                    w_carry_nxt = r_carry | w_cla_co;
                    w_rem_nxt   = r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ACC;
                    end
                end else begin
                    w_state_nxt = ST_ACC;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= 16'h0000;
            r_carry     <= 1'b0;
            r_rem       <= {LEN_W{1'b0}};
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_carry     <= w_carry_nxt;
            r_rem       <= w_rem_nxt;
            r_in_ready  <= (w_state_nxt == ST_ACC);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_sum   = r_acc;
    assign out_carry = r_carry;

endmodule

// Four 4-bit lookahead groups joined by a second lookahead level.
module CLA16 (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Co
);

    function automatic logic [3:0] cla4_sum(input logic [3:0] a, input logic [3:0] b,
                                            input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return p ^ c;
    endfunction

    function automatic logic [1:0] cla4_gp(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] g;
        logic [3:0] p;
        g = a & b;
        p = a | b;
        return {g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p};
    endfunction

    logic [3:0] w_gg;
    logic [3:0] w_gp;
    logic [4:0] w_c;

    for (genvar k = 0; k < 4; k++) begin : g_grp
        assign {w_gg[k], w_gp[k]} = cla4_gp(A[4*k+3:4*k], B[4*k+3:4*k]);
        assign S[4*k+3:4*k]       = cla4_sum(A[4*k+3:4*k], B[4*k+3:4*k], w_c[k]);
    end

    assign w_c[0] = Cin;
    assign w_c[1] = w_gg[0] | (w_gp[0] & Cin);
    assign w_c[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & Cin);
    assign w_c[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[2] & w_gp[1] & w_gp[0] & Cin);
    assign w_c[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & Cin);
    assign Co     = w_c[4];

endmodule
